// File: rtl/cory_merge2_pkg.sv
// Shared encodings for the cory_merge2 two-to-one stream merge.
// Lock state encodings are only used when CORY_MERGE2_LAST_LOCK_EN is defined.
package cory_merge2_pkg;

  localparam logic SRC_A0 = 1'b0;
  localparam logic SRC_A1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } lock_e;

  localparam logic [1:0] SKID_DEPTH = 2'd2;

endpackage

// File: rtl/cory_merge2_arb.sv
// Round-robin grant logic for cory_merge2; holds prio and, when
// CORY_MERGE2_LAST_LOCK_EN is defined, the packet lock state.
module cory_merge2_arb
  import cory_merge2_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a0_v,
  input  logic a0_l,
  input  logic a1_v,
  input  logic a1_l,
  input  logic space,
  output logic g0,
  output logic g1
);

  logic prio_q, prio_d;
  logic ok0, ok1;

`ifdef CORY_MERGE2_LAST_LOCK_EN
  lock_e st_q, st_d;

  always_comb begin
    ok0 = a0_v & space & ~reset & (st_q != LOCK1);
    ok1 = a1_v & space & ~reset & (st_q != LOCK0);
    g0 = ok0 & (~ok1 | (prio_q == SRC_A0));
    g1 = ok1 & (~ok0 | (prio_q == SRC_A1));
    prio_d = prio_q;
    st_d = st_q;
    // prio only moves when a packet ends
    unique case (1'b1)
      g0: begin
        if (a0_l) begin
          st_d = IDLE;
          prio_d = SRC_A1;
        end else begin
          st_d = LOCK0;
        end
      end
      g1: begin
        if (a1_l) begin
          st_d = IDLE;
          prio_d = SRC_A0;
        end else begin
          st_d = LOCK1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= SRC_A0;
      st_q <= IDLE;
    end else begin
      prio_q <= prio_d;
      st_q <= st_d;
    end
  end
`else
  logic unused_l;
  assign unused_l = a0_l ^ a1_l;

  always_comb begin
    ok0 = a0_v & space & ~reset;
    ok1 = a1_v & space & ~reset;
    g0 = ok0 & (~ok1 | (prio_q == SRC_A0));
    g1 = ok1 & (~ok0 | (prio_q == SRC_A1));
    prio_d = prio_q;
    unique case (1'b1)
      g0: prio_d = SRC_A1;
      g1: prio_d = SRC_A0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= SRC_A0;
    end else begin
      prio_q <= prio_d;
    end
  end
`endif

endmodule

// File: rtl/cory_merge2.sv
// Two-to-one valid/ready merge with a registered 2-entry skid output.
// Define CORY_MERGE2_LAST_LOCK_EN to keep packets (last flag) contiguous.
module cory_merge2
  import cory_merge2_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_a0_v,
  input  logic [N-1:0] i_a0_d,
  input  logic         i_a0_l,
  output logic         o_a0_r,
  input  logic         i_a1_v,
  input  logic [N-1:0] i_a1_d,
  input  logic         i_a1_l,
  output logic         o_a1_r,
  output logic         o_z_v,
  output logic [N-1:0] o_z_d,
  output logic         o_z_l,
  output logic         o_z_s,
  input  logic         i_z_r
);

  logic [1:0]   cnt_q, cnt_d;
  logic [N-1:0] dat_q [2];
  logic [N-1:0] dat_d [2];
  logic [1:0]   lst_q, lst_d;
  logic [1:0]   src_q, src_d;
  logic         space, push, pop, wr_idx;
  logic         g0, g1;

  assign space = (cnt_q < SKID_DEPTH);
  assign push = g0 | g1;
  assign pop = o_z_v & i_z_r;

  cory_merge2_arb u_arb (
    .clk   (clk),
    .reset (reset),
    .a0_v  (i_a0_v),
    .a0_l  (i_a0_l),
    .a1_v  (i_a1_v),
    .a1_l  (i_a1_l),
    .space (space),
    .g0    (g0),
    .g1    (g1)
  );

  // entry 0 is always the head; a pop shifts entry 1 down
  always_comb begin
    dat_d = dat_q;
    lst_d = lst_q;
    src_d = src_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    wr_idx = pop ? 1'b0 : cnt_q[0];
    if (pop) begin
      dat_d[0] = dat_q[1];
      lst_d[0] = lst_q[1];
      src_d[0] = src_q[1];
    end
    if (push) begin
      dat_d[wr_idx] = g1 ? i_a1_d : i_a0_d;
      lst_d[wr_idx] = g1 ? i_a1_l : i_a0_l;
      src_d[wr_idx] = g1 ? SRC_A1 : SRC_A0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 2'd0;
      dat_q[0] <= '0;
      dat_q[1] <= '0;
      lst_q <= 2'b00;
      src_q <= 2'b00;
    end else begin
      cnt_q <= cnt_d;
      dat_q[0] <= dat_d[0];
      dat_q[1] <= dat_d[1];
      lst_q <= lst_d;
      src_q <= src_d;
    end
  end

  assign o_z_v = (cnt_q != 2'd0);
  assign o_z_d = dat_q[0];
  assign o_z_l = lst_q[0];
  assign o_z_s = src_q[0];
  assign o_a0_r = g0;
  assign o_a1_r = g1;

endmodule

// File: tb/tb_cory_merge2.sv
// Directed self-checking bench for cory_merge2.
// Lock expectations follow CORY_MERGE2_LAST_LOCK_EN.
module tb_cory_merge2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_a0_v = 1'b0;
  logic [7:0] i_a0_d = '0;
  logic       i_a0_l = 1'b0;
  logic       o_a0_r;
  logic       i_a1_v = 1'b0;
  logic [7:0] i_a1_d = '0;
  logic       i_a1_l = 1'b0;
  logic       o_a1_r;
  logic       o_z_v;
  logic [7:0] o_z_d;
  logic       o_z_l;
  logic       o_z_s;
  logic       i_z_r = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cory_merge2 #(.N(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .i_a0_v (i_a0_v),
    .i_a0_d (i_a0_d),
    .i_a0_l (i_a0_l),
    .o_a0_r (o_a0_r),
    .i_a1_v (i_a1_v),
    .i_a1_d (i_a1_d),
    .i_a1_l (i_a1_l),
    .o_a1_r (o_a1_r),
    .o_z_v  (o_z_v),
    .o_z_d  (o_z_d),
    .o_z_l  (o_z_l),
    .o_z_s  (o_z_s),
    .i_z_r  (i_z_r)
  );

  always @(negedge clk) begin
    n_vec++;
    if (o_a0_r && o_a1_r) begin
      n_err++;
      $display("FAIL both_ready: got r0=%b r1=%b want not both 1",
               o_a0_r, o_a1_r);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_a0_v = 1'b0;
    i_a1_v = 1'b0;
    i_z_r = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_a0_v = 1'b1;
    i_a1_v = 1'b1;
    i_z_r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_vec++;
      if ({o_a0_r, o_a1_r, o_z_v} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got r0r1v=%b want 000",
                 i, {o_a0_r, o_a1_r, o_z_v});
      end
    end
    n_vec++;
    if ({o_z_d, o_z_l, o_z_s} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_outs: got d=%h l=%b s=%b want 0",
               o_z_d, o_z_l, o_z_s);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if ({o_a0_r, o_a1_r} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_first_grant: got r0r1=%b want 10",
               {o_a0_r, o_a1_r});
    end
    i_a0_v = 1'b0;
    i_a1_v = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h11;
    exp_d[1] = 8'h22;
    exp_d[2] = 8'h33;
    do_reset();
    i_z_r = 1'b1;
    i_a0_v = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_a0_d = exp_d[k];
      i_a0_l = (k == 2);
      #1;
      n_vec++;
      if (o_a0_r !== 1'b1) begin
        n_err++;
        $display("FAIL single_ready[%0d]: got %b want 1", k, o_a0_r);
      end
      cyc();
      n_vec++;
      if ({o_z_v, o_z_s, o_z_d} !== {2'b10, exp_d[k]}) begin
        n_err++;
        $display("FAIL single_out[%0d]: got v=%b s=%b d=%h want v=1 s=0 d=%h",
                 k, o_z_v, o_z_s, o_z_d, exp_d[k]);
      end
    end
    n_vec++;
    if (o_z_l !== 1'b1) begin
      n_err++;
      $display("FAIL single_last: got %b want 1", o_z_l);
    end
    i_a0_v = 1'b0;
    cyc();
    n_vec++;
    if (o_z_v !== 1'b0) begin
      n_err++;
      $display("FAIL single_drain: got v=%b want 0", o_z_v);
    end
  endtask

  task automatic test_tie();
    logic r0s, r1s;
    logic [7:0] exp_d;
    do_reset();
    i_z_r = 1'b1;
    i_a0_v = 1'b1;
    i_a0_d = 8'hA0;
    i_a1_v = 1'b1;
    i_a1_d = 8'hB0;
    for (int k = 0; k < 6; k++) begin
      #1;
      r0s = o_a0_r;
      r1s = o_a1_r;
      n_vec++;
      if ({r0s, r1s} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_err++;
        $display("FAIL tie_ready[%0d]: got r0r1=%b want one-hot alternating",
                 k, {r0s, r1s});
      end
      cyc();
      if (r0s) i_a0_d = i_a0_d + 8'd1;
      if (r1s) i_a1_d = i_a1_d + 8'd1;
      exp_d = (k % 2 == 1) ? 8'hB0 + 8'(k / 2) : 8'hA0 + 8'(k / 2);
      n_vec++;
      if ({o_z_v, o_z_s, o_z_d} !== {1'b1, 1'(k % 2), exp_d}) begin
        n_err++;
        $display("FAIL tie_out[%0d]: got v=%b s=%b d=%h want v=1 s=%0d d=%h",
                 k, o_z_v, o_z_s, o_z_d, k % 2, exp_d);
      end
    end
  endtask

  task automatic test_backpressure();
    logic r0s, r1s;
    do_reset();
    i_z_r = 1'b0;
    i_a0_v = 1'b1;
    i_a0_d = 8'hA0;
    i_a1_v = 1'b1;
    i_a1_d = 8'hB0;
    for (int k = 0; k < 5; k++) begin
      #1;
      r0s = o_a0_r;
      r1s = o_a1_r;
      n_vec++;
      if ({r0s, r1s} !== {k == 0, k == 1}) begin
        n_err++;
        $display("FAIL bp_ready[%0d]: got r0r1=%b want %b%b",
                 k, {r0s, r1s}, k == 0, k == 1);
      end
      cyc();
      if (r0s) i_a0_d = i_a0_d + 8'd1;
      if (r1s) i_a1_d = i_a1_d + 8'd1;
      n_vec++;
      if ({o_z_v, o_z_s, o_z_d} !== {2'b10, 8'hA0}) begin
        n_err++;
        $display("FAIL bp_stall[%0d]: got v=%b s=%b d=%h want v=1 s=0 d=a0",
                 k, o_z_v, o_z_s, o_z_d);
      end
    end
    i_z_r = 1'b1;
    #1;
    n_vec++;
    if ({o_a0_r, o_a1_r} !== 2'b00) begin
      n_err++;
      $display("FAIL bp_full_pop: got r0r1=%b want 00", {o_a0_r, o_a1_r});
    end
    i_a0_v = 1'b0;
    i_a1_v = 1'b0;
    cyc();
    n_vec++;
    if ({o_z_v, o_z_s, o_z_d} !== {2'b11, 8'hB0}) begin
      n_err++;
      $display("FAIL bp_drain: got v=%b s=%b d=%h want v=1 s=1 d=b0",
               o_z_v, o_z_s, o_z_d);
    end
    cyc();
    n_vec++;
    if (o_z_v !== 1'b0) begin
      n_err++;
      $display("FAIL bp_empty: got v=%b want 0", o_z_v);
    end
  endtask

  task automatic test_lock();
    logic [8:0] exp_b [4];
    logic [7:0] pk_d [3];
    logic       pk_l [3];
    logic r0s, r1s;
    int ia;
    pk_d[0] = 8'hC1;
    pk_d[1] = 8'hC2;
    pk_d[2] = 8'hC3;
    pk_l[0] = 1'b0;
    pk_l[1] = 1'b0;
    pk_l[2] = 1'b1;
`ifdef CORY_MERGE2_LAST_LOCK_EN
    exp_b[0] = {1'b0, 8'hC1};
    exp_b[1] = {1'b0, 8'hC2};
    exp_b[2] = {1'b0, 8'hC3};
    exp_b[3] = {1'b1, 8'hD1};
`else
    exp_b[0] = {1'b0, 8'hC1};
    exp_b[1] = {1'b1, 8'hD1};
    exp_b[2] = {1'b0, 8'hC2};
    exp_b[3] = {1'b0, 8'hC3};
`endif
    do_reset();
    i_z_r = 1'b1;
    ia = 0;
    i_a0_v = 1'b1;
    i_a1_v = 1'b1;
    i_a1_d = 8'hD1;
    i_a1_l = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (ia < 3) begin
        i_a0_d = pk_d[ia];
        i_a0_l = pk_l[ia];
      end
      #1;
      r0s = o_a0_r;
      r1s = o_a1_r;
      n_vec++;
      if ({r0s, r1s} !== {!exp_b[k][8], exp_b[k][8]}) begin
        n_err++;
        $display("FAIL lock_ready[%0d]: got r0r1=%b want src %b",
                 k, {r0s, r1s}, exp_b[k][8]);
      end
      cyc();
      if (r0s) ia++;
      if (ia == 3) i_a0_v = 1'b0;
      if (r1s) i_a1_v = 1'b0;
      n_vec++;
      if ({o_z_s, o_z_d} !== exp_b[k]) begin
        n_err++;
        $display("FAIL lock_out[%0d]: got s=%b d=%h want s=%b d=%h",
                 k, o_z_s, o_z_d, exp_b[k][8], exp_b[k][7:0]);
      end
    end
    i_a0_v = 1'b0;
    i_a1_v = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_z_r = 1'b0;
    i_a0_v = 1'b1;
    i_a0_d = 8'hE0;
    i_a0_l = 1'b1;
    cyc();
    cyc();
    i_a1_v = 1'b1;
    i_a1_d = 8'hF0;
    i_a1_l = 1'b1;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({o_a0_r, o_a1_r, o_z_v} !== 3'b001) begin
      n_err++;
      $display("FAIL rmid_full: got r0r1v=%b want 001",
               {o_a0_r, o_a1_r, o_z_v});
    end
    cyc();
    n_vec++;
    if ({o_z_v, o_z_d} !== 9'd0) begin
      n_err++;
      $display("FAIL rmid_flush: got v=%b d=%h want v=0 d=00", o_z_v, o_z_d);
    end
    reset = 1'b0;
    i_z_r = 1'b1;
    i_a0_d = 8'hE1;
    #1;
    n_vec++;
    if ({o_a0_r, o_a1_r} !== 2'b10) begin
      n_err++;
      $display("FAIL rmid_prio: got r0r1=%b want 10", {o_a0_r, o_a1_r});
    end
    cyc();
    i_a0_v = 1'b0;
    n_vec++;
    if ({o_z_v, o_z_s, o_z_d} !== {2'b10, 8'hE1}) begin
      n_err++;
      $display("FAIL rmid_beat0: got v=%b s=%b d=%h want v=1 s=0 d=e1",
               o_z_v, o_z_s, o_z_d);
    end
    #1;
    n_vec++;
    if ({o_a0_r, o_a1_r} !== 2'b01) begin
      n_err++;
      $display("FAIL rmid_grant1: got r0r1=%b want 01", {o_a0_r, o_a1_r});
    end
    cyc();
    i_a1_v = 1'b0;
    n_vec++;
    if ({o_z_v, o_z_s, o_z_d} !== {2'b11, 8'hF0}) begin
      n_err++;
      $display("FAIL rmid_beat1: got v=%b s=%b d=%h want v=1 s=1 d=f0",
               o_z_v, o_z_s, o_z_d);
    end
    cyc();
    n_vec++;
    if (o_z_v !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_empty: got v=%b want 0", o_z_v);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_lock();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
